// File: rtl/csi_seq_pkg.sv
// Shared types for the CSI-2 frame sequencer: FSM state encoding and err_o bit map.
package csi_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_LINE      = 2'd2,
    ST_BLANK     = 2'd3
  } seq_state_e;

  localparam int ERR_W       = 5;
  localparam int ERR_LEN     = 0;
  localparam int ERR_OVERRUN = 1;
  localparam int ERR_TRUNC   = 2;
  localparam int ERR_NO_FE   = 3;
  localparam int ERR_TIMEOUT = 4;

endpackage

// File: rtl/csi_frame_sequencer_if.sv
// Packet-decoder side events in, pixel-pipeline line/frame controls out.
interface csi_frame_sequencer_if
  import csi_seq_pkg::*;
#(
  parameter int WORD_CNT_W = 12,
  parameter int LINE_CNT_W = 12
);
  logic                  frame_start_i;
  logic                  frame_end_i;
  logic                  packet_valid_i;
  logic                  data_valid_i;
  logic [WORD_CNT_W-1:0] expected_words_i;
  logic                  line_valid_o;
  logic                  frame_sync_o;
  logic                  bayer_odd_o;
  logic [LINE_CNT_W-1:0] line_count_o;
  logic [WORD_CNT_W-1:0] word_count_o;
  logic [ERR_W-1:0]      err_o;
  logic                  frame_done_o;

  modport master (
    output frame_start_i, frame_end_i, packet_valid_i, data_valid_i, expected_words_i,
    input  line_valid_o, frame_sync_o, bayer_odd_o, line_count_o, word_count_o,
           err_o, frame_done_o
  );

  modport slave (
    input  frame_start_i, frame_end_i, packet_valid_i, data_valid_i, expected_words_i,
    output line_valid_o, frame_sync_o, bayer_odd_o, line_count_o, word_count_o,
           err_o, frame_done_o
  );
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter that stops at zero; load has priority over decrement.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
endmodule

// File: rtl/csi_frame_sequencer.sv
// CSI-2 frame/line sequencer for the RAW pipeline; CSI_FRAME_TIMEOUT_EN adds a WAIT/BLANK watchdog.
// state      | meaning
// IDLE       | between frames, packets ignored
// WAIT_LINE  | inside a frame, blanking satisfied, waiting for a payload
// LINE       | payload active, counting words
// BLANK      | enforcing the minimum line_valid_o low time after a line
module csi_frame_sequencer
  import csi_seq_pkg::*;
#(
  parameter int WORD_CNT_W     = 12,
  parameter int LINE_CNT_W     = 12,
  parameter int MIN_BLANK      = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                  clk_i,
  input logic                  reset_i,
  csi_frame_sequencer_if.slave bus
);
  localparam int BLANK_W = (MIN_BLANK > 1) ? $clog2(MIN_BLANK) : 1;

  seq_state_e            state_q, state_d;
  logic                  line_valid_q, line_valid_d;
  logic                  frame_sync_q, frame_sync_d;
  logic                  bayer_odd_q, bayer_odd_d;
  logic [LINE_CNT_W-1:0] line_count_q, line_count_d;
  logic [WORD_CNT_W-1:0] word_count_q, word_count_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  frame_done_q, frame_done_d;
  logic [WORD_CNT_W-1:0] word_inc, word_next;
  logic                  do_close;
  logic                  blank_load, blank_dec, blank_zero;
  logic                  wd_expired;

  if (MIN_BLANK < 1) begin : g_bad_min_blank
    $error("MIN_BLANK must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign blank_dec = (state_q == ST_BLANK);

  seq_down_counter #(.W(BLANK_W)) u_blank_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (blank_load),
    .load_val_i (BLANK_W'(MIN_BLANK - 1)),
    .dec_i      (blank_dec),
    .zero_o     (blank_zero)
  );

`ifdef CSI_FRAME_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic wd_load, wd_dec, wd_zero;

  // Held loaded everywhere except WAIT_LINE/BLANK, so entering LINE clears it.
  assign wd_dec  = (state_q == ST_WAIT_LINE) || (state_q == ST_BLANK);
  assign wd_load = bus.frame_start_i || !wd_dec;

  seq_down_counter #(.W(WD_W)) u_wd_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (wd_load),
    .load_val_i (WD_W'(TIMEOUT_CYCLES - 1)),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );
  assign wd_expired = wd_dec && wd_zero;
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    frame_sync_d = frame_sync_q;
    bayer_odd_d  = bayer_odd_q;
    line_count_d = line_count_q;
    word_count_d = word_count_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    blank_load   = 1'b0;
    do_close     = 1'b0;
    word_inc     = (&word_count_q) ? word_count_q : word_count_q + WORD_CNT_W'(1);
    word_next    = bus.data_valid_i ? word_inc : word_count_q;

    if (bus.frame_start_i) begin
      state_d      = ST_WAIT_LINE;
      line_valid_d = 1'b0;
      frame_sync_d = 1'b1;
      bayer_odd_d  = 1'b0;
      line_count_d = '0;
      word_count_d = '0;
      err_d        = '0;
      // The restart clear must not hide the fact that a frame end went missing.
      if (state_q != ST_IDLE) err_d[ERR_NO_FE] = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_WAIT_LINE: begin
          if (bus.frame_end_i) begin
            do_close = 1'b1;
          end else if (wd_expired) begin
            do_close             = 1'b1;
            err_d[ERR_TIMEOUT]   = 1'b1;
          end else if (bus.packet_valid_i) begin
            state_d      = ST_LINE;
            line_valid_d = 1'b1;
            word_count_d = '0;
          end
        end
        ST_LINE: begin
          word_count_d = word_next;
          if (bus.frame_end_i) begin
            do_close         = 1'b1;
            err_d[ERR_TRUNC] = 1'b1;
          end else if (!bus.packet_valid_i) begin
            state_d      = ST_BLANK;
            line_valid_d = 1'b0;
            line_count_d = line_count_q + LINE_CNT_W'(1);
            bayer_odd_d  = !bayer_odd_q;
            blank_load   = 1'b1;
            if ((bus.expected_words_i != '0) && (word_next != bus.expected_words_i)) begin
              err_d[ERR_LEN] = 1'b1;
            end
          end
        end
        ST_BLANK: begin
          if (bus.frame_end_i) begin
            do_close = 1'b1;
          end else if (wd_expired) begin
            do_close           = 1'b1;
            err_d[ERR_TIMEOUT] = 1'b1;
          end else if (bus.packet_valid_i) begin
            state_d      = ST_LINE;
            line_valid_d = 1'b1;
            word_count_d = '0;
            if (!blank_zero) err_d[ERR_OVERRUN] = 1'b1;
          end else if (blank_zero) begin
            state_d = ST_WAIT_LINE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (do_close) begin
        state_d      = ST_IDLE;
        line_valid_d = 1'b0;
        frame_sync_d = 1'b0;
        frame_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      line_valid_q <= 1'b0;
      frame_sync_q <= 1'b0;
      bayer_odd_q  <= 1'b0;
      line_count_q <= '0;
      word_count_q <= '0;
      err_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      frame_sync_q <= frame_sync_d;
      bayer_odd_q  <= bayer_odd_d;
      line_count_q <= line_count_d;
      word_count_q <= word_count_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.line_valid_o = line_valid_q;
  assign bus.frame_sync_o = frame_sync_q;
  assign bus.bayer_odd_o  = bayer_odd_q;
  assign bus.line_count_o = line_count_q;
  assign bus.word_count_o = word_count_q;
  assign bus.err_o        = err_q;
  assign bus.frame_done_o = frame_done_q;
endmodule
